// File: rtl/timer_irq_gen_if.sv
//------------------------------------------------------------------------------
// Module   : timer_irq_gen_if
// Brief    : Data-bus slave port of the countdown timer (address/strobe/data).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface timer_irq_gen_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output addr, output we, output wdata, input rdata);
  modport slave  (input addr, input we, input wdata, output rdata);
endinterface

`default_nettype wire

// File: rtl/timer_irq_gen.sv
//------------------------------------------------------------------------------
// Module   : timer_irq_gen
// Brief    : Memory-mapped countdown timer raising a level IRQ on expiry.
//            Optional prescaler enabled by macro TIMER_PRESCALE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module timer_irq_gen #(
  parameter int CNT_W = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  timer_irq_gen_if.slave     bus,
  output logic               irq
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_LOAD = 2'd1;
  localparam logic [1:0] c_CNT  = 2'd2;
  localparam logic [1:0] c_INT  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic             r_en;
  logic [1:0]       r_mode;
  logic             r_im;
  logic             r_pending;
  logic [CNT_W-1:0] r_preset;
  logic [CNT_W-1:0] r_count;

  logic             w_wr_ctrl;
  logic             w_wr_preset;
  logic             w_tick;
  logic             w_auto;
  logic             w_last;
  logic             w_load;
  logic             w_dec;
  logic             w_int;
  logic [7:0]       w_ps_rd;
  logic [31:0]      w_preset_rd;
  logic [31:0]      w_count_rd;
  logic             w_unused;

  assign w_wr_ctrl   = bus.we && (bus.addr[3:2] == 2'd0);
  assign w_wr_preset = bus.we && (bus.addr[3:2] == 2'd1);
  // MODE encodings 2 and 3 fall back to one-shot
  assign w_auto      = (r_mode == 2'd1);
  assign w_last      = (r_count <= CNT_W'(1));
  assign w_unused    = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata};

`ifdef TIMER_PRESCALE_EN
  logic [7:0] r_prescale;
  logic [7:0] r_pscnt;

  assign w_tick  = (r_pscnt == r_prescale);
  assign w_ps_rd = r_prescale;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prescale <= 8'h00;
      r_pscnt    <= 8'h00;
    end else begin
      if (w_wr_ctrl)
        r_prescale <= bus.wdata[15:8];
      if ((r_state != c_CNT) || w_tick)
        r_pscnt <= 8'h00;
      else
        r_pscnt <= r_pscnt + 8'h01;
    end
  end
`else
  assign w_tick  = 1'b1;
  assign w_ps_rd = 8'h00;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_state <= c_IDLE;
    else
      r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: if (r_en) w_next_state = c_LOAD;
      c_LOAD: w_next_state = c_CNT;
      c_CNT: begin
        if (!r_en)
          w_next_state = c_IDLE;
        else if (w_tick && w_last)
          w_next_state = c_INT;
      end
      c_INT:  w_next_state = w_auto ? c_LOAD : c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  // State-decoded datapath controls
  always_comb begin
    w_load = 1'b0;
    w_dec  = 1'b0;
    w_int  = 1'b0;
    case (r_state)
      c_LOAD:  w_load = 1'b1;
      c_CNT:   w_dec  = r_en && w_tick;
      c_INT:   w_int  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en      <= 1'b0;
      r_mode    <= 2'd0;
      r_im      <= 1'b0;
      r_pending <= 1'b0;
      r_preset  <= '0;
      r_count   <= '0;
    end else begin
      // A CTRL write takes priority over the INT-state side effects
      if (w_wr_ctrl) begin
        r_en   <= bus.wdata[0];
        r_mode <= bus.wdata[2:1];
        r_im   <= bus.wdata[3];
      end else if (w_int && !w_auto) begin
        r_en   <= 1'b0;
      end

      // LOAD only follows INT in auto-reload, giving a one-cycle pending pulse
      if (w_wr_ctrl)
        r_pending <= 1'b0;
      else if (w_int)
        r_pending <= 1'b1;
      else if (w_load)
        r_pending <= 1'b0;

      if (w_wr_preset)
        r_preset <= bus.wdata[CNT_W-1:0];

      if (w_load)
        r_count <= r_preset;
      else if (w_dec)
        r_count <= w_last ? '0 : (r_count - CNT_W'(1));
    end
  end

  generate
    if (CNT_W < 32) begin : g_ext_pad
      assign w_preset_rd = {{(32-CNT_W){1'b0}}, r_preset};
      assign w_count_rd  = {{(32-CNT_W){1'b0}}, r_count};
    end else begin : g_ext_full
      assign w_preset_rd = r_preset;
      assign w_count_rd  = r_count;
    end
  endgenerate

  always_comb begin
    bus.rdata = 32'h0;
    case (bus.addr[3:2])
      2'd0:    bus.rdata = {16'h0, w_ps_rd, 4'h0, r_im, r_mode, r_en};
      2'd1:    bus.rdata = w_preset_rd;
      2'd2:    bus.rdata = w_count_rd;
      default: bus.rdata = 32'h0;
    endcase
  end

  assign irq = r_pending & r_im;

endmodule

`default_nettype wire
